// File: rtl/em_cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and default datapath widths.
// The PC block uses the same ADDR_MSB / INSTR_W defaults.
package em_cpu_pkg;

  // Default address MSB index (addresses are [ADDR_MSB:0])
  localparam int unsigned ADDR_MSB = 11;
  // Default instruction word width
  localparam int unsigned INSTR_W  = 16;
  // Width of the optional performance counters
  localparam int unsigned PERF_W   = 16;
  // Width of the fetch FSM state register
  localparam int unsigned STATE_W  = 2;

  // Fetch FSM state encoding
  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_REQ  = 2'd1;
  localparam logic [STATE_W-1:0] S_WAIT = 2'd2;
  localparam logic [STATE_W-1:0] S_HOLD = 2'd3;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: PC block, instruction memory and decode handshakes.
// master = fetch unit, slave = surrounding PC / memory / decode logic.
interface instr_fetch_if import em_cpu_pkg::*; #(
  parameter int unsigned WIDTH  = ADDR_MSB,
  parameter int unsigned DATA_W = INSTR_W
);

  // PC block
  logic [WIDTH:0]    pc;
  logic              inc_pc;
  // Instruction memory read port
  logic              mem_req;
  logic [WIDTH:0]    mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  // Branch redirect
  logic              flush;
  // Decode handshake
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [WIDTH:0]    instr_pc;

  modport master (
    input  pc,
    output inc_pc,
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    input  flush,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc
  );

  modport slave (
    output pc,
    input  inc_pc,
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    output flush,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc
  );

endinterface

// File: rtl/ifetch_perf_counters.sv
// Free-running fetch performance counters (accepted fetches, wait-state cycles).
// Only built when IFETCH_PERF_EN is defined; both counters wrap 0xFFFF -> 0.
`ifdef IFETCH_PERF_EN
module ifetch_perf_counters import em_cpu_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_pc,
  input  logic              stall,
  output logic [PERF_W-1:0] perf_fetches,
  output logic [PERF_W-1:0] perf_stalls
);

  // Count accepted decode handshakes and cycles spent waiting on memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetches <= '0;
      perf_stalls  <= '0;
    end else begin
      if (inc_pc) begin
        perf_fetches <= perf_fetches + PERF_W'(1);
      end
      if (stall) begin
        perf_stalls <= perf_stalls + PERF_W'(1);
      end
    end
  end

endmodule
`endif

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads the word at pc over a req/ack memory port,
// hands it to decode with a valid/ready handshake and strobes inc_pc on accept.
// A flush drops any in-flight or held word; a request already issued is never
// withdrawn, its data is discarded when the ack arrives.
// Optional build macro: IFETCH_PERF_EN adds perf_fetches / perf_stalls outputs.
module instr_fetch import em_cpu_pkg::*; #(
  parameter int unsigned WIDTH  = ADDR_MSB,
  parameter int unsigned DATA_W = INSTR_W
) (
  input  logic              clk,
  input  logic              rst,
  instr_fetch_if.master     bus
`ifdef IFETCH_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_fetches,
  output logic [PERF_W-1:0] perf_stalls
`endif
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [WIDTH:0]     mem_addr_q, mem_addr_d;
  logic               instr_valid_q, instr_valid_d;
  logic [DATA_W-1:0]  instr_q, instr_d;
  logic [WIDTH:0]     instr_pc_q, instr_pc_d;
  logic               discard_q, discard_d;
  logic               inc_pc_c;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      discard_q     <= discard_d;
    end
  end

  // Next-state, next-output and the combinational inc_pc strobe
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    discard_d     = discard_q;
    inc_pc_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        // During a flush the PC is being reloaded; issue on the next cycle
        // so the request carries the redirect target.
        if (!bus.flush) begin
          mem_addr_d = bus.pc;
          mem_req_d  = 1'b1;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          if (discard_q || bus.flush) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            instr_d       = bus.mem_rdata;
            instr_pc_d    = mem_addr_q;
            instr_valid_d = 1'b1;
            state_d       = S_HOLD;
          end
        end else if (bus.flush) begin
          // Request stays up; remember to drop its data
          discard_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (bus.flush) begin
          // Redirect voids the handshake even when decode is ready
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end else if (instr_valid_q && bus.instr_ready) begin
          inc_pc_c      = 1'b1;
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Drive the bus from the registered state
  assign bus.inc_pc      = inc_pc_c;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

`ifdef IFETCH_PERF_EN
  logic stall_c;

  // Wait-state indicator for the stall counter
  assign stall_c = (state_q == S_WAIT);

  ifetch_perf_counters u_perf (
    .clk          (clk),
    .rst          (rst),
    .inc_pc       (inc_pc_c),
    .stall        (stall_c),
    .perf_fetches (perf_fetches),
    .perf_stalls  (perf_stalls)
  );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: PC block and memory models, a decode
// scoreboard, table-driven fetches and hand-written flush / wrap / reset cases.
// Build with IFETCH_PERF_EN to also check the performance counters.
`timescale 1ns/1ps
module tb_instr_fetch;
  import em_cpu_pkg::*;

  typedef struct packed {
    logic [11:0] pc;
    logic [15:0] word;
  } exp_t;

  typedef struct {
    logic [11:0] pc;
    logic [15:0] word;
    int          lat;
    int          stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if #(.WIDTH(ADDR_MSB), .DATA_W(INSTR_W)) bus ();

`ifdef IFETCH_PERF_EN
  logic [15:0] perf_fetches;
  logic [15:0] perf_stalls;
`endif

  instr_fetch #(.WIDTH(ADDR_MSB), .DATA_W(INSTR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetches (perf_fetches),
    .perf_stalls  (perf_stalls)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  int          inc_cnt = 0;
  int          lat = 2;
  int          mem_cnt;
  logic [11:0] flush_tgt;
  exp_t        exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Memory contents: address folded into the pattern 0xA5A5
  function automatic logic [15:0] mem_fn(input logic [11:0] a);
    return 16'hA5A5 ^ {a, 4'h0};
  endfunction

  // PC block model: redirect load wins over increment, 12-bit wrap
  always @(posedge clk or posedge rst) begin
    if (rst)             bus.pc <= '0;
    else if (bus.flush)  bus.pc <= flush_tgt;
    else if (bus.inc_pc) bus.pc <= bus.pc + 12'd1;
  end

  // Memory model: ack one cycle, lat cycles after the request is seen
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_ack   <= 1'b0;
      bus.mem_rdata <= '0;
      mem_cnt       <= 0;
    end else begin
      bus.mem_ack <= 1'b0;
      if (bus.mem_req && !bus.mem_ack) begin
        if (mem_cnt >= lat - 1) begin
          bus.mem_ack   <= 1'b1;
          bus.mem_rdata <= mem_fn(bus.mem_addr);
          mem_cnt       <= 0;
        end else begin
          mem_cnt <= mem_cnt + 1;
        end
      end
    end
  end

  // Decode-side checker, sampled mid-cycle
  logic        hold_prev;
  logic [15:0] instr_prev;
  logic [11:0] ipc_prev;
  logic        hs;
  exp_t        got;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev <= 1'b0;
    end else begin
      hs = bus.instr_valid && bus.instr_ready && !bus.flush;
      chk("inc_pc_strobe", 32'(bus.inc_pc), 32'(hs));
      if (bus.inc_pc) inc_cnt++;
      if (hold_prev && bus.instr_valid) begin
        chk("hold_instr_stable", 32'(bus.instr), 32'(instr_prev));
        chk("hold_pc_stable", 32'(bus.instr_pc), 32'(ipc_prev));
      end
      if (hs) begin
        chk("sb_has_expect", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          chk("sb_instr", 32'(bus.instr), 32'(got.word));
          chk("sb_instr_pc", 32'(bus.instr_pc), 32'(got.pc));
        end
      end
      hold_prev  <= bus.instr_valid && !bus.instr_ready && !bus.flush;
      instr_prev <= bus.instr;
      ipc_prev   <= bus.instr_pc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [11:0] pc, input logic [15:0] word);
    exp_t e;
    e.pc   = pc;
    e.word = word;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.instr_valid && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_valid_seen"}, 32'(bus.instr_valid), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus.mem_req && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_req_seen"}, 32'(bus.mem_req), 32'd1);
  endtask

  // Hold ready low for 'stall' cycles, then accept; expect exactly one inc_pc
  task automatic accept(input int stall, input string tag);
    int base = inc_cnt;
    repeat (stall) tick();
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk({tag, "_one_inc"}, 32'(inc_cnt), 32'(base + 1));
    chk({tag, "_valid_drop"}, 32'(bus.instr_valid), 32'd0);
  endtask

  task automatic fetch(input vec_t v, input string tag);
    lat = v.lat;
    push_exp(v.pc, v.word);
    wait_valid(tag);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(v.pc));
    accept(v.stall, tag);
  endtask

  initial begin
    vec_t        vecs[4];
    logic [11:0] old_addr;
    int          base;
    int          n;

    vecs[0] = '{pc: 12'h000, word: 16'hA5A5, lat: 2, stall: 0};
    vecs[1] = '{pc: 12'h001, word: 16'hA5B5, lat: 1, stall: 5};
    vecs[2] = '{pc: 12'h002, word: 16'hA585, lat: 3, stall: 0};
    vecs[3] = '{pc: 12'h003, word: 16'hA595, lat: 1, stall: 2};

    rst             = 1'b1;
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;
    flush_tgt       = '0;
    tick();
    tick();
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_inc_pc", 32'(bus.inc_pc), 32'd0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'd0);
    chk("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
    rst = 1'b0;

    // Sequential fetches with varying memory latency and backpressure
    for (int i = 0; i < 4; i++) begin
      fetch(vecs[i], $sformatf("vec%0d", i));
    end

    // Flush while waiting on memory: request held, data dropped, refetch at 0x040
    lat = 4;
    wait_req("s3");
    old_addr  = bus.mem_addr;
    flush_tgt = 12'h040;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n = 0;
    while (!bus.mem_ack && n < 20) begin
      chk("s3_req_held", 32'(bus.mem_req), 32'd1);
      chk("s3_addr_stable", 32'(bus.mem_addr), 32'(old_addr));
      tick();
      n++;
    end
    chk("s3_ack_seen", 32'(bus.mem_ack), 32'd1);
    tick();
    chk("s3_dropped", 32'(bus.instr_valid), 32'd0);
    chk("s3_req_done", 32'(bus.mem_req), 32'd0);
    push_exp(12'h040, 16'hA1A5);
    wait_valid("s3_refetch");
    chk("s3_refetch_addr", 32'(bus.mem_addr), 32'h040);
    accept(0, "s3");

    // Flush coinciding with valid & ready: handshake void, no inc_pc
    lat = 2;
    wait_valid("s4");
    base            = inc_cnt;
    flush_tgt       = 12'hFFF;
    bus.flush       = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    bus.flush       = 1'b0;
    bus.instr_ready = 1'b0;
    chk("s4_valid_drop", 32'(bus.instr_valid), 32'd0);
    chk("s4_no_inc", 32'(inc_cnt), 32'(base));

    // Fetch at the top address, then the PC wraps to 0
    push_exp(12'hFFF, 16'h5A55);
    wait_valid("s5");
    chk("s5_addr_fff", 32'(bus.mem_addr), 32'hFFF);
    accept(1, "s5");
    push_exp(12'h000, 16'hA5A5);
    wait_valid("s5_wrap");
    chk("s5_addr_wrap", 32'(bus.mem_addr), 32'h000);
    accept(0, "s5_wrap");

    // Reset in the middle of a memory wait
    lat = 10;
    wait_req("s6");
    tick();
    chk("s6_sb_empty", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;
    #1;
    chk("s6_req_clear", 32'(bus.mem_req), 32'd0);
    chk("s6_valid_clear", 32'(bus.instr_valid), 32'd0);
`ifdef IFETCH_PERF_EN
    chk("s6_perf_fetches_rst", 32'(perf_fetches), 32'd0);
    chk("s6_perf_stalls_rst", 32'(perf_stalls), 32'd0);
`endif
    tick();
    tick();
    rst = 1'b0;

    // Three back-to-back fetches from reset
    for (int i = 0; i < 3; i++) begin
      vec_t v;
      v = '{pc: 12'(i), word: mem_fn(12'(i)), lat: 2, stall: 0};
      fetch(v, $sformatf("rep%0d", i));
    end
`ifdef IFETCH_PERF_EN
    chk("perf_fetches", 32'(perf_fetches), 32'd3);
    chk("perf_stalls", 32'(perf_stalls), 32'd9);
`endif

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
